// File: rtl/estagio_id_ex.sv
// ID/EX pipeline register: captures decoded operands and control, forwards MEM/WB results.
// Define ENCAMINHAMENTO_EN to enable MEM/WB forwarding and operand refresh during stall.
module estagio_id_ex #(
    parameter int unsigned LARGURA   = 8,
    parameter int unsigned BITS_REG  = 3,
    parameter logic [2:0]  SINAL_NOP = 3'b111
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic                valido_id,
    input  logic [LARGURA-1:0]  dado_rs_id,
    input  logic [LARGURA-1:0]  dado_rt_id,
    input  logic [LARGURA-1:0]  imediato_id,
    input  logic [BITS_REG-1:0] rs_id,
    input  logic [BITS_REG-1:0] rt_id,
    input  logic [BITS_REG-1:0] rd_id,
    input  logic [2:0]          sinal_ula_id,
    input  logic                usa_imediato_id,
    input  logic                escreve_reg_id,
    input  logic                escreve_reg_mem,
    input  logic [BITS_REG-1:0] rd_mem,
    input  logic [LARGURA-1:0]  resultado_mem,
    input  logic                escreve_reg_wb,
    input  logic [BITS_REG-1:0] rd_wb,
    input  logic [LARGURA-1:0]  resultado_wb,
    output logic [LARGURA-1:0]  entrada1,
    output logic [LARGURA-1:0]  entrada2,
    output logic [2:0]          sinal_ula,
    output logic [LARGURA-1:0]  dado_rt_ex,
    output logic [BITS_REG-1:0] rd_ex,
    output logic                escreve_reg_ex,
    output logic                valido_ex
);

    logic                valido_q;
    logic                escreve_reg_q;
    logic                usa_imediato_q;
    logic [2:0]          sinal_ula_q;
    logic [BITS_REG-1:0] rs_q;
    logic [BITS_REG-1:0] rt_q;
    logic [BITS_REG-1:0] rd_q;
    logic [LARGURA-1:0]  dado_rs_q;
    logic [LARGURA-1:0]  dado_rt_q;
    logic [LARGURA-1:0]  imediato_q;

    logic [LARGURA-1:0]  rs_fwd;
    logic [LARGURA-1:0]  rt_fwd;
    logic                carrega_bolha;

`ifdef ENCAMINHAMENTO_EN
    logic mem_rs, mem_rt, wb_rs, wb_rt;

    // Index 0 never matches; bubbles store index 0 and are gated by valido_q as well.
    always_comb begin
        mem_rs = valido_q && escreve_reg_mem && (rd_mem != '0) && (rd_mem == rs_q);
        mem_rt = valido_q && escreve_reg_mem && (rd_mem != '0) && (rd_mem == rt_q);
        wb_rs  = valido_q && escreve_reg_wb  && (rd_wb  != '0) && (rd_wb  == rs_q);
        wb_rt  = valido_q && escreve_reg_wb  && (rd_wb  != '0) && (rd_wb  == rt_q);
        rs_fwd = dado_rs_q;
        rt_fwd = dado_rt_q;
        if (mem_rs) begin
            rs_fwd = resultado_mem;
        end else if (wb_rs) begin
            rs_fwd = resultado_wb;
        end
        if (mem_rt) begin
            rt_fwd = resultado_mem;
        end else if (wb_rt) begin
            rt_fwd = resultado_wb;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{escreve_reg_mem, rd_mem, resultado_mem,
                          escreve_reg_wb, rd_wb, resultado_wb, rs_q, rt_q};
    assign rs_fwd = dado_rs_q;
    assign rt_fwd = dado_rt_q;
`endif

    assign carrega_bolha = flush || (!stall && !valido_id);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valido_q       <= 1'b0;
            escreve_reg_q  <= 1'b0;
            usa_imediato_q <= 1'b0;
            sinal_ula_q    <= SINAL_NOP;
            rs_q           <= '0;
            rt_q           <= '0;
            rd_q           <= '0;
            dado_rs_q      <= '0;
            dado_rt_q      <= '0;
            imediato_q     <= '0;
        end else if (carrega_bolha) begin
            valido_q       <= 1'b0;
            escreve_reg_q  <= 1'b0;
            usa_imediato_q <= 1'b0;
            sinal_ula_q    <= SINAL_NOP;
            rs_q           <= '0;
            rt_q           <= '0;
            rd_q           <= '0;
            dado_rs_q      <= '0;
            dado_rt_q      <= '0;
            imediato_q     <= '0;
        end else if (stall) begin
`ifdef ENCAMINHAMENTO_EN
            // Keep a result that retires from WB while we wait.
            dado_rs_q <= rs_fwd;
            dado_rt_q <= rt_fwd;
`endif
        end else begin
            valido_q       <= 1'b1;
            escreve_reg_q  <= escreve_reg_id;
            usa_imediato_q <= usa_imediato_id;
            sinal_ula_q    <= sinal_ula_id;
            rs_q           <= rs_id;
            rt_q           <= rt_id;
            rd_q           <= rd_id;
            dado_rs_q      <= (rs_id == '0) ? '0 : dado_rs_id;
            dado_rt_q      <= (rt_id == '0) ? '0 : dado_rt_id;
            imediato_q     <= imediato_id;
        end
    end

    assign entrada1       = rs_fwd;
    assign entrada2       = usa_imediato_q ? imediato_q : rt_fwd;
    assign dado_rt_ex     = rt_fwd;
    assign sinal_ula      = sinal_ula_q;
    assign rd_ex          = rd_q;
    assign escreve_reg_ex = escreve_reg_q;
    assign valido_ex      = valido_q;

endmodule

// File: tb/tb_estagio_id_ex.sv
// Self-checking bench for estagio_id_ex: directed scenarios plus randomized traffic
// against a behavioural model; follows ENCAMINHAMENTO_EN like the design.
module tb_estagio_id_ex;

`ifdef ENCAMINHAMENTO_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       stall = 1'b0, flush = 1'b0, valido_id = 1'b0;
    logic [7:0] dado_rs_id = '0, dado_rt_id = '0, imediato_id = '0;
    logic [2:0] rs_id = '0, rt_id = '0, rd_id = '0, sinal_ula_id = '0;
    logic       usa_imediato_id = 1'b0, escreve_reg_id = 1'b0;
    logic       escreve_reg_mem = 1'b0, escreve_reg_wb = 1'b0;
    logic [2:0] rd_mem = '0, rd_wb = '0;
    logic [7:0] resultado_mem = '0, resultado_wb = '0;
    logic [7:0] entrada1, entrada2, dado_rt_ex;
    logic [2:0] sinal_ula, rd_ex;
    logic       escreve_reg_ex, valido_ex;

    int checks = 0;
    int errors = 0;

    estagio_id_ex dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush), .valido_id(valido_id),
        .dado_rs_id(dado_rs_id), .dado_rt_id(dado_rt_id), .imediato_id(imediato_id),
        .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id), .sinal_ula_id(sinal_ula_id),
        .usa_imediato_id(usa_imediato_id), .escreve_reg_id(escreve_reg_id),
        .escreve_reg_mem(escreve_reg_mem), .rd_mem(rd_mem), .resultado_mem(resultado_mem),
        .escreve_reg_wb(escreve_reg_wb), .rd_wb(rd_wb), .resultado_wb(resultado_wb),
        .entrada1(entrada1), .entrada2(entrada2), .sinal_ula(sinal_ula),
        .dado_rt_ex(dado_rt_ex), .rd_ex(rd_ex), .escreve_reg_ex(escreve_reg_ex),
        .valido_ex(valido_ex)
    );

    always #5 clock = ~clock;

    // Reference model: contents of the stage as an instruction record.
    logic       m_valid, m_wr, m_usa;
    logic [2:0] m_op, m_rd, m_rs, m_rt;
    logic [7:0] m_vrs, m_vrt, m_imm;

    task automatic model_bubble();
        m_valid = 0; m_wr = 0; m_usa = 0; m_op = 3'b111;
        m_rd = 0; m_rs = 0; m_rt = 0; m_vrs = 0; m_vrt = 0; m_imm = 0;
    endtask

    // Value of register idx as seen by the execute stage right now.
    function automatic logic [7:0] fwd(input logic [2:0] idx, input logic [7:0] stored);
        if (!FWD || !m_valid || idx == 0) return stored;
        if (escreve_reg_mem && rd_mem == idx) return resultado_mem;
        if (escreve_reg_wb && rd_wb == idx) return resultado_wb;
        return stored;
    endfunction

    function automatic logic [7:0] exp_e1();
        return fwd(m_rs, m_vrs);
    endfunction
    function automatic logic [7:0] exp_rt();
        return fwd(m_rt, m_vrt);
    endfunction
    function automatic logic [7:0] exp_e2();
        return m_usa ? m_imm : fwd(m_rt, m_vrt);
    endfunction

    // Advance one clock: compute model's next state from inputs held across the edge.
    task automatic tick();
        logic [7:0] nrs, nrt;
        bit bolha, hold, load;
        bolha = flush || (!stall && !valido_id);
        hold  = !flush && stall;
        load  = !bolha && !hold;
        nrs = fwd(m_rs, m_vrs);
        nrt = fwd(m_rt, m_vrt);
        @(posedge clock);
        if (bolha) model_bubble();
        else if (hold) begin
            m_vrs = nrs; m_vrt = nrt;
        end else if (load) begin
            m_valid = 1; m_wr = escreve_reg_id; m_usa = usa_imediato_id; m_op = sinal_ula_id;
            m_rd = rd_id; m_rs = rs_id; m_rt = rt_id; m_imm = imediato_id;
            m_vrs = (rs_id == 0) ? 8'h00 : dado_rs_id;
            m_vrt = (rt_id == 0) ? 8'h00 : dado_rt_id;
        end
        #1;
    endtask

    task automatic set_instr(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt,
                             input logic [2:0] rd, input logic [7:0] vrs, input logic [7:0] vrt,
                             input logic usa, input logic [7:0] imm);
        valido_id = 1; escreve_reg_id = 1; sinal_ula_id = op; rs_id = rs; rt_id = rt;
        rd_id = rd; dado_rs_id = vrs; dado_rt_id = vrt; usa_imediato_id = usa; imediato_id = imm;
    endtask

    task automatic wb_idle();
        escreve_reg_mem = 0; rd_mem = 0; resultado_mem = 0;
        escreve_reg_wb = 0; rd_wb = 0; resultado_wb = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        set_instr(3'b011, 3'd5, 3'd6, 3'd7, 8'h9C, 8'h3D, 1'b0, 8'h12);
        escreve_reg_mem = 1; rd_mem = 5; resultado_mem = 8'hE1;
        model_bubble();
        repeat (2) @(posedge clock);
        #2;
        checks++; if (sinal_ula !== 3'b111) begin errors++;
            $display("FAIL reset_sinal_ula got %b want 111", sinal_ula); end
        checks++; if (valido_ex !== 1'b0 || escreve_reg_ex !== 1'b0) begin errors++;
            $display("FAIL reset_valid got v=%b w=%b want 0 0", valido_ex, escreve_reg_ex); end
        checks++; if (entrada1 !== 8'h00 || entrada2 !== 8'h00) begin errors++;
            $display("FAIL reset_operands got %h %h want 00 00", entrada1, entrada2); end
        wb_idle();
        set_instr(3'b010, 3'd1, 3'd2, 3'd3, 8'h05, 8'h03, 1'b0, 8'h00);
        reset = 1;
        tick();
        checks++; if (sinal_ula !== 3'b010 || valido_ex !== 1'b1) begin errors++;
            $display("FAIL first_load_ctrl got op=%b v=%b want 010 1", sinal_ula, valido_ex); end
        checks++; if (entrada1 !== 8'h05 || entrada2 !== 8'h03) begin errors++;
            $display("FAIL first_load_ops got %h %h want 05 03", entrada1, entrada2); end
    endtask

    task automatic test_immediate();
        set_instr(3'b010, 3'd1, 3'd4, 3'd2, 8'h21, 8'h11, 1'b1, 8'hFE);
        tick();
        checks++; if (entrada2 !== 8'hFE) begin errors++;
            $display("FAIL imm_entrada2 got %h want fe", entrada2); end
        checks++; if (dado_rt_ex !== 8'h11) begin errors++;
            $display("FAIL imm_dado_rt got %h want 11", dado_rt_ex); end
    endtask

    task automatic test_forwarding();
        logic [7:0] want;
        set_instr(3'b000, 3'd2, 3'd5, 3'd6, 8'h05, 8'h07, 1'b0, 8'h00);
        tick();
        escreve_reg_mem = 1; rd_mem = 2; resultado_mem = 8'hAA;
        escreve_reg_wb = 1; rd_wb = 2; resultado_wb = 8'hBB;
        #1;
        want = FWD ? 8'hAA : 8'h05;
        checks++; if (entrada1 !== want) begin errors++;
            $display("FAIL fwd_mem_prio got %h want %h", entrada1, want); end
        escreve_reg_mem = 0;
        #1;
        want = FWD ? 8'hBB : 8'h05;
        checks++; if (entrada1 !== want) begin errors++;
            $display("FAIL fwd_wb got %h want %h", entrada1, want); end
        escreve_reg_mem = 1; rd_mem = 0; rd_wb = 0;
        set_instr(3'b001, 3'd0, 3'd5, 3'd6, 8'h77, 8'h07, 1'b0, 8'h00);
        tick();
        checks++; if (entrada1 !== 8'h00) begin errors++;
            $display("FAIL fwd_r0 got %h want 00", entrada1); end
        wb_idle();
    endtask

    task automatic test_stall_wb();
        logic [7:0] want;
        set_instr(3'b011, 3'd1, 3'd3, 3'd4, 8'h20, 8'h10, 1'b0, 8'h00);
        tick();
        stall = 1;
        set_instr(3'b100, 3'd6, 3'd7, 3'd5, 8'h66, 8'h77, 1'b0, 8'h00);
        escreve_reg_wb = 1; rd_wb = 3; resultado_wb = 8'h42;
        tick();
        wb_idle();
        want = FWD ? 8'h42 : 8'h10;
        for (int i = 0; i < 3; i++) begin
            checks++; if (entrada2 !== want || sinal_ula !== 3'b011) begin errors++;
                $display("FAIL stall_hold[%0d] got e2=%h op=%b want e2=%h op=011",
                         i, entrada2, sinal_ula, want); end
            tick();
        end
        stall = 0;
        tick();
        checks++; if (valido_ex !== 1'b1 || sinal_ula !== 3'b100 || entrada1 !== 8'h66) begin
            errors++;
            $display("FAIL stall_release got v=%b op=%b e1=%h want 1 100 66",
                     valido_ex, sinal_ula, entrada1); end
    endtask

    task automatic test_flush();
        set_instr(3'b010, 3'd4, 3'd2, 3'd1, 8'h33, 8'h44, 1'b0, 8'h00);
        tick();
        flush = 1; stall = 1;
        escreve_reg_mem = 1; rd_mem = 4; resultado_mem = 8'h99;
        tick();
        checks++; if (valido_ex !== 1'b0 || escreve_reg_ex !== 1'b0 || sinal_ula !== 3'b111) begin
            errors++;
            $display("FAIL flush_ctrl got v=%b w=%b op=%b want 0 0 111",
                     valido_ex, escreve_reg_ex, sinal_ula); end
        checks++; if (entrada1 !== 8'h00 || rd_ex !== 3'd0) begin errors++;
            $display("FAIL flush_ops got e1=%h rd=%0d want 00 0", entrada1, rd_ex); end
        flush = 0; stall = 0;
        wb_idle();
    endtask

    task automatic test_async_reset();
        set_instr(3'b001, 3'd3, 3'd5, 3'd2, 8'h5A, 8'hA5, 1'b0, 8'h00);
        tick();
        checks++; if (valido_ex !== 1'b1) begin errors++;
            $display("FAIL async_pre got v=%b want 1", valido_ex); end
        #1 reset = 0;
        #1;
        checks++; if (valido_ex !== 1'b0 || sinal_ula !== 3'b111 || entrada1 !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got v=%b op=%b e1=%h want 0 111 00",
                     valido_ex, sinal_ula, entrada1); end
        model_bubble();
        #1 reset = 1;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(99) < 20);
            flush = ($urandom_range(99) < 8);
            valido_id = ($urandom_range(99) < 85);
            dado_rs_id = 8'($urandom); dado_rt_id = 8'($urandom); imediato_id = 8'($urandom);
            rs_id = 3'($urandom); rt_id = 3'($urandom); rd_id = 3'($urandom);
            sinal_ula_id = 3'($urandom_range(4));
            usa_imediato_id = $urandom_range(1); escreve_reg_id = $urandom_range(1);
            escreve_reg_mem = $urandom_range(1); rd_mem = 3'($urandom);
            resultado_mem = 8'($urandom);
            escreve_reg_wb = $urandom_range(1); rd_wb = 3'($urandom);
            resultado_wb = 8'($urandom);
            #1;
            checks++;
            if (entrada1 !== exp_e1() || entrada2 !== exp_e2() || dado_rt_ex !== exp_rt() ||
                sinal_ula !== m_op || rd_ex !== m_rd || escreve_reg_ex !== m_wr ||
                valido_ex !== m_valid) begin
                errors++;
                $display("FAIL random[%0d] got e1=%h e2=%h rt=%h op=%b rd=%0d w=%b v=%b want e1=%h e2=%h rt=%h op=%b rd=%0d w=%b v=%b",
                         i, entrada1, entrada2, dado_rt_ex, sinal_ula, rd_ex, escreve_reg_ex,
                         valido_ex, exp_e1(), exp_e2(), exp_rt(), m_op, m_rd, m_wr, m_valid);
            end
            tick();
        end
        stall = 0; flush = 0;
        wb_idle();
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_forwarding();
        test_stall_wb();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
